// File: rtl/fifo_level_pkg.sv
// Shared types and helpers for the arbitrary-depth valid/ready FIFO (fifo_level_vr).
package fifo_level_pkg;

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_PUSH,
        OP_POP,
        OP_PUSH_POP,
        OP_BYPASS
    } fifo_op_e;

    // Wrap-around increment for pointers that live in 0..depth-1.
    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
        return (ptr >= depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

    // A depth of one still needs a one-bit pointer.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 32'd1) ? $clog2(depth) : 32'd1;
    endfunction

endpackage

// File: rtl/fifo_wrap_ctr.sv
// Pointer counter that runs 0..MAX-1 and wraps explicitly, so MAX need not be a power of two.
module fifo_wrap_ctr
    import fifo_level_pkg::*;
#(
    parameter int unsigned MAX = 5,
    localparam int unsigned W = ptr_width(MAX)
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= W'(next_ptr(32'(r_cnt), MAX));
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/fifo_level_vr.sv
// Valid/ready FIFO of any depth with fill level, almost-full/almost-empty flags and sync flush.
// Define FIFO_LEVEL_VR_BYPASS_EN to let a word pass straight through an empty FIFO in the same cycle.
module fifo_level_vr
    import fifo_level_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 5,
    parameter int unsigned AF_THRESH  = 4,
    parameter int unsigned AE_THRESH  = 1,
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  put_valid,
    output logic                  put_ready,
    input  logic [DATA_WIDTH-1:0] put_data,
    output logic                  get_valid,
    input  logic                  get_ready,
    output logic [DATA_WIDTH-1:0] get_data,
    output logic [CNT_W-1:0]      level,
    output logic                  almost_full,
    output logic                  almost_empty
);

    localparam int unsigned      PTR_W   = ptr_width(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_L = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_L    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_L    = CNT_W'(AE_THRESH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0]      r_level;
    logic [PTR_W-1:0]      w_rd_ptr;
    logic [PTR_W-1:0]      w_wr_ptr;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_get_valid;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_bypass;
    logic [DATA_WIDTH-1:0] w_head;
    fifo_op_e              w_op;

    assign w_empty   = (r_level == '0);
    assign w_full    = (r_level == DEPTH_L);
    // A full FIFO can still take a word when the consumer drains one in the same cycle.
    assign put_ready = ~flush & (~w_full | get_ready);

`ifdef FIFO_LEVEL_VR_BYPASS_EN
    assign w_get_valid = ~flush & (w_empty ? put_valid : 1'b1);
    assign w_head      = w_empty ? put_data : r_mem[w_rd_ptr];
    assign w_bypass    = w_empty & w_push & w_pop;
`else
    assign w_get_valid = ~flush & ~w_empty;
    assign w_head      = r_mem[w_rd_ptr];
    assign w_bypass    = 1'b0;
`endif

    assign get_valid = w_get_valid;
    assign get_data  = w_get_valid ? w_head : '0;
    assign w_push    = put_valid & put_ready;
    assign w_pop     = w_get_valid & get_ready;

    always_comb begin
        w_op = OP_IDLE;
        if (w_bypass) begin
            w_op = OP_BYPASS;
        end else if (w_push && w_pop) begin
            w_op = OP_PUSH_POP;
        end else if (w_push) begin
            w_op = OP_PUSH;
        end else if (w_pop) begin
            w_op = OP_POP;
        end
    end

    fifo_wrap_ctr #(.MAX(DEPTH)) u_wr_ptr (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_clr   (flush),
        .i_inc   ((w_op == OP_PUSH) || (w_op == OP_PUSH_POP)),
        .o_cnt   (w_wr_ptr)
    );

    fifo_wrap_ctr #(.MAX(DEPTH)) u_rd_ptr (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_clr   (flush),
        .i_inc   ((w_op == OP_POP) || (w_op == OP_PUSH_POP)),
        .o_cnt   (w_rd_ptr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_level <= '0;
        end else if (flush) begin
            r_level <= '0;
        end else begin
            case (w_op)
                OP_PUSH: r_level <= r_level + CNT_W'(1);
                OP_POP:  r_level <= r_level - CNT_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage is deliberately left unreset; the level and pointers define what is valid.
    always_ff @(posedge clk) begin
        if ((w_op == OP_PUSH) || (w_op == OP_PUSH_POP)) begin
            r_mem[w_wr_ptr] <= put_data;
        end
    end

    assign level        = r_level;
    assign almost_full  = (r_level >= AF_L);
    assign almost_empty = (r_level <= AE_L);

endmodule

// File: tb/tb_fifo_level_vr.sv
// Directed bench for fifo_level_vr: a DEPTH=5 instance and a DEPTH=1 instance with queue scoreboards.
module tb_fifo_level_vr;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;

    logic       flush = 1'b0;
    logic       putValid = 1'b0;
    logic [7:0] putData = 8'h00;
    logic       getReady = 1'b0;
    logic       putReady;
    logic       getValid;
    logic [7:0] getData;
    logic [2:0] level;
    logic       almostFull;
    logic       almostEmpty;

    logic       flushOne = 1'b0;
    logic       putValidOne = 1'b0;
    logic [7:0] putDataOne = 8'h00;
    logic       getReadyOne = 1'b0;
    logic       putReadyOne;
    logic       getValidOne;
    logic [7:0] getDataOne;
    logic [0:0] levelOne;
    logic       almostFullOne;
    logic       almostEmptyOne;

    int testsRun = 0;
    int testsFailed = 0;

    logic [7:0] expQ[$];
    logic [7:0] expQOne[$];

    always #5 clk = ~clk;

    fifo_level_vr #(.DATA_WIDTH(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1)) dut (
        .clk          (clk),
        .reset        (resetN),
        .flush        (flush),
        .put_valid    (putValid),
        .put_ready    (putReady),
        .put_data     (putData),
        .get_valid    (getValid),
        .get_ready    (getReady),
        .get_data     (getData),
        .level        (level),
        .almost_full  (almostFull),
        .almost_empty (almostEmpty)
    );

    fifo_level_vr #(.DATA_WIDTH(8), .DEPTH(1), .AF_THRESH(1), .AE_THRESH(0)) dutOne (
        .clk          (clk),
        .reset        (resetN),
        .flush        (flushOne),
        .put_valid    (putValidOne),
        .put_ready    (putReadyOne),
        .put_data     (putDataOne),
        .get_valid    (getValidOne),
        .get_ready    (getReadyOne),
        .get_data     (getDataOne),
        .level        (levelOne),
        .almost_full  (almostFullOne),
        .almost_empty (almostEmptyOne)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic pv, input logic [7:0] pd, input logic gr, input logic fl);
        @(posedge clk);
        #1;
        putValid = pv;
        putData  = pd;
        getReady = gr;
        flush    = fl;
        @(negedge clk);
    endtask

    task automatic applyStimulusOne(input logic pv, input logic [7:0] pd, input logic gr);
        @(posedge clk);
        #1;
        putValidOne = pv;
        putDataOne  = pd;
        getReadyOne = gr;
        @(negedge clk);
    endtask

    // Every accepted word becomes the next expected output of that instance.
    always @(negedge clk) begin
        if (resetN && putValid && putReady) expQ.push_back(putData);
        if (resetN && putValidOne && putReadyOne) expQOne.push_back(putDataOne);
    end

    // Monitor: compare each delivered word against the head of the scoreboard queue.
    always @(negedge clk) begin
        #1;
        if (resetN && getValid && getReady) begin
            if (expQ.size() == 0) checkOutput("dut5_unexpected_word", 32'(getData), 32'hFFFF_FFFF);
            else checkOutput("dut5_order", 32'(getData), 32'(expQ.pop_front()));
        end
        if (resetN && getValidOne && getReadyOne) begin
            if (expQOne.size() == 0) checkOutput("dut1_unexpected_word", 32'(getDataOne), 32'hFFFF_FFFF);
            else checkOutput("dut1_order", 32'(getDataOne), 32'(expQOne.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int idx;
        int cyc;
        int maxLevel;

        @(negedge clk);
        checkOutput("rst_level", 32'(level), 32'd0);
        checkOutput("rst_put_ready", 32'(putReady), 32'd1);
        checkOutput("rst_get_valid", 32'(getValid), 32'd0);
        checkOutput("rst_almost_empty", 32'(almostEmpty), 32'd1);
        checkOutput("rst_almost_full", 32'(almostFull), 32'd0);
        checkOutput("rst_level_d1", 32'(levelOne), 32'd0);
        @(posedge clk);
        #1;
        resetN = 1'b1;

        // Test 1: reset in the middle of a fill discards everything
        for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("t1_level_before_reset", 32'(level), 32'd3);
        @(posedge clk);
        #1;
        resetN = 1'b0;
        putValid = 1'b0;
        getReady = 1'b0;
        @(negedge clk);
        checkOutput("t1_level", 32'(level), 32'd0);
        checkOutput("t1_get_valid", 32'(getValid), 32'd0);
        checkOutput("t1_put_ready", 32'(putReady), 32'd1);
        checkOutput("t1_almost_empty", 32'(almostEmpty), 32'd1);
        expQ.delete();
        expQOne.delete();
        @(posedge clk);
        #1;
        resetN = 1'b1;
        applyStimulus(1'b1, 8'h10, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("t1_get_valid_after", 32'(getValid), 32'd1);
        checkOutput("t1_get_data_after", 32'(getData), 32'h10);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("t1_level_after", 32'(level), 32'd0);

        // Test 2: fill to full, then push+pop at full, then drain
        for (int i = 0; i <= 5; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
            checkOutput($sformatf("t2_level_%0d", i), 32'(level), 32'(i));
            checkOutput($sformatf("t2_put_ready_%0d", i), 32'(putReady), (i < 5) ? 32'd1 : 32'd0);
            checkOutput($sformatf("t2_almost_full_%0d", i), 32'(almostFull), (i >= 4) ? 32'd1 : 32'd0);
            checkOutput($sformatf("t2_almost_empty_%0d", i), 32'(almostEmpty), (i <= 1) ? 32'd1 : 32'd0);
        end
        applyStimulus(1'b1, 8'h05, 1'b1, 1'b0);
        checkOutput("t2_full_put_ready", 32'(putReady), 32'd1);
        checkOutput("t2_full_head", 32'(getData), 32'h00);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("t2_level_after_push_pop", 32'(level), 32'd5);
        checkOutput("t2_head_after_push_pop", 32'(getData), 32'h01);
        repeat (4) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("t2_level_drained", 32'(level), 32'd0);

        // Test 3: stream twelve words with a stuttering consumer so both pointers wrap twice
        idx = 0;
        cyc = 0;
        maxLevel = 0;
        while (idx < 12 && cyc < 80) begin
            applyStimulus(1'b1, 8'(idx), (cyc % 2) == 1, 1'b0);
            if (putReady) idx++;
            if (int'(level) > maxLevel) maxLevel = int'(level);
            cyc++;
        end
        checkOutput("t3_all_pushed", 32'(idx), 32'd12);
        cyc = 0;
        do begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            if (int'(level) > maxLevel) maxLevel = int'(level);
            cyc++;
        end while (level != 3'd0 && cyc < 20);
        checkOutput("t3_drained", 32'(level), 32'd0);
        checkOutput("t3_level_bounded", 32'(maxLevel <= 5), 32'd1);
        checkOutput("t3_level_reached_full", 32'(maxLevel), 32'd5);

        // Test 4: flush with three words stored
        applyStimulus(1'b1, 8'h31, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h32, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h44, 1'b1, 1'b1);
        checkOutput("t4_level_at_flush", 32'(level), 32'd3);
        checkOutput("t4_put_ready", 32'(putReady), 32'd0);
        checkOutput("t4_get_valid", 32'(getValid), 32'd0);
        expQ.delete();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("t4_level_after", 32'(level), 32'd0);
        checkOutput("t4_almost_empty", 32'(almostEmpty), 32'd1);
        checkOutput("t4_get_valid_after", 32'(getValid), 32'd0);
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("t4_first_word_after_flush", 32'(getData), 32'h55);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("t4_level_end", 32'(level), 32'd0);

        // Test 5: offer a word to an empty FIFO with the consumer ready
        applyStimulus(1'b1, 8'hA5, 1'b1, 1'b0);
`ifdef FIFO_LEVEL_VR_BYPASS_EN
        checkOutput("t5_bypass_valid", 32'(getValid), 32'd1);
        checkOutput("t5_bypass_data", 32'(getData), 32'hA5);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("t5_bypass_level", 32'(level), 32'd0);
        checkOutput("t5_bypass_valid_next", 32'(getValid), 32'd0);
`else
        checkOutput("t5_valid_same_cycle", 32'(getValid), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("t5_valid_next", 32'(getValid), 32'd1);
        checkOutput("t5_data_next", 32'(getData), 32'hA5);
        checkOutput("t5_level_next", 32'(level), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("t5_level_end", 32'(level), 32'd0);
`endif

        // Test 6: single-entry FIFO
        applyStimulusOne(1'b1, 8'h11, 1'b0);
        checkOutput("t6_level_empty", 32'(levelOne), 32'd0);
        checkOutput("t6_put_ready_empty", 32'(putReadyOne), 32'd1);
        checkOutput("t6_almost_empty_empty", 32'(almostEmptyOne), 32'd1);
        checkOutput("t6_get_valid_empty", 32'(getValidOne), 32'd0);
        applyStimulusOne(1'b1, 8'h22, 1'b0);
        checkOutput("t6_level_full", 32'(levelOne), 32'd1);
        checkOutput("t6_put_ready_full", 32'(putReadyOne), 32'd0);
        checkOutput("t6_almost_full_full", 32'(almostFullOne), 32'd1);
        checkOutput("t6_almost_empty_full", 32'(almostEmptyOne), 32'd0);
        checkOutput("t6_get_valid_full", 32'(getValidOne), 32'd1);
        applyStimulusOne(1'b1, 8'h22, 1'b1);
        checkOutput("t6_put_ready_drain", 32'(putReadyOne), 32'd1);
        checkOutput("t6_head_first", 32'(getDataOne), 32'h11);
        for (int i = 3; i <= 6; i++) begin
            applyStimulusOne(1'b1, 8'(i * 17), 1'b1);
            checkOutput($sformatf("t6_stream_level_%0d", i), 32'(levelOne), 32'd1);
            checkOutput($sformatf("t6_stream_ready_%0d", i), 32'(putReadyOne), 32'd1);
            checkOutput($sformatf("t6_stream_head_%0d", i), 32'(getDataOne), 32'((i - 1) * 17));
        end
        applyStimulusOne(1'b0, 8'h00, 1'b1);
        checkOutput("t6_last_head", 32'(getDataOne), 32'h66);
        applyStimulusOne(1'b0, 8'h00, 1'b0);
        checkOutput("t6_level_end", 32'(levelOne), 32'd0);

        @(negedge clk);
        #2;
        checkOutput("dut5_all_words_delivered", 32'(expQ.size()), 32'd0);
        checkOutput("dut1_all_words_delivered", 32'(expQOne.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
